// File: rtl/apb_event_ctrl.sv
// APB interrupt/event controller: synchronised sources, edge/level capture, pending and mask
// registers, lowest-index IRQ priority with ack, and a core sleep/wake sequencer.
module apb_event_ctrl #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int NB_LINES       = 32,
    parameter int SYNC_STAGES    = 2,
    parameter int WAKE_CYCLES    = 4
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [NB_LINES-1:0]       src_i,
    output logic [NB_LINES-1:0]       irq_o,
    output logic                      irq_valid_o,
    output logic [4:0]                irq_id_o,
    input  logic                      irq_ack_i,
    input  logic                      core_busy_i,
    output logic                      fetch_en_o,
    output logic                      clk_gate_core_o
);

    localparam int CW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

    typedef enum logic [2:0] {
        RUN       = 3'd0,
        WAIT_IDLE = 3'd1,
        SLEEP     = 3'd2,
        WAKE      = 3'd3
    } state_t;

    state_t              state;
    logic [CW-1:0]       wake_cnt;
    logic [NB_LINES-1:0] mask_irq, mask_evt, edge_sel, pending, prev;
    logic [NB_LINES-1:0] s, set, clr, sw_set, ack_clr, pending_next, pw;
    logic                access, mapped, wr, w;
    logic [2:0]          idx;
    logic                unused_addr;

    assign unused_addr = ^PADDR[1:0];

    // Source synchroniser; depth 0 feeds the raw inputs straight through.
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = src_i;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0][NB_LINES-1:0] q;
            always_ff @(posedge HCLK or negedge HRESETn) begin
                if (!HRESETn) begin
                    q <= '0;
                end else begin
                    q[0] <= src_i;
                    for (int i = 1; i < SYNC_STAGES; i++) q[i] <= q[i-1];
                end
            end
            assign s = q[SYNC_STAGES-1];
        end
    endgenerate

    assign access = PSEL & PENABLE;
    assign mapped = (PADDR[APB_ADDR_WIDTH-1:5] == '0);
    assign idx    = PADDR[4:2];
    assign wr     = access & PWRITE & mapped;
    assign pw     = PWDATA[NB_LINES-1:0];

    assign PREADY  = 1'b1;
    assign PSLVERR = access & ~mapped;

    assign irq_valid_o = |irq_o;
    always_comb begin
        irq_id_o = '0;
        for (int i = NB_LINES - 1; i >= 0; i--)
            if (irq_o[i]) irq_id_o = 5'(i);
    end

    // Ack only retires the id currently presented, and only while something is presented.
    assign ack_clr      = (irq_ack_i & irq_valid_o) ? (NB_LINES'(1) << irq_id_o) : '0;
    assign set          = (edge_sel & s & ~prev) | (~edge_sel & s);
    assign sw_set       = (wr && idx == 3'd2) ? pw : '0;
    assign clr          = ((wr && idx == 3'd3) ? pw : '0) | ack_clr;
    assign pending_next = (pending & ~clr) | set | sw_set;
    assign w            = |(pending & (mask_irq | mask_evt));

    always_comb begin
        PRDATA = '0;
        if (mapped) begin
            case (idx)
                3'd0:    PRDATA = 32'(mask_irq);
                3'd1:    PRDATA = 32'(mask_evt);
                3'd2:    PRDATA = 32'(pending);
                3'd4:    PRDATA = 32'(edge_sel);
                3'd5:    PRDATA = {irq_valid_o, 26'b0, irq_id_o};
                3'd7:    PRDATA = {29'b0, state};
                default: PRDATA = '0;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            mask_irq        <= '0;
            mask_evt        <= '0;
            edge_sel        <= '0;
            pending         <= '0;
            prev            <= '0;
            irq_o           <= '0;
            state           <= RUN;
            wake_cnt        <= '0;
            fetch_en_o      <= 1'b1;
            clk_gate_core_o <= 1'b1;
        end else begin
            if (wr && idx == 3'd0) mask_irq <= pw;
            if (wr && idx == 3'd1) mask_evt <= pw;
            if (wr && idx == 3'd4) edge_sel <= pw;
            prev    <= s;
            pending <= pending_next;
            irq_o   <= pending & mask_irq;

            // Outputs are set alongside the state they belong to, so they change with it.
            case (state)
                RUN: begin
                    if (wr && idx == 3'd6 && PWDATA[0]) begin
                        state      <= WAIT_IDLE;
                        fetch_en_o <= 1'b0;
                    end
                end
                WAIT_IDLE: begin
                    if (w) begin
                        state      <= RUN;
                        fetch_en_o <= 1'b1;
                    end else if (!core_busy_i) begin
                        state           <= SLEEP;
                        clk_gate_core_o <= 1'b0;
                    end
                end
                SLEEP: begin
                    if (w) begin
                        state           <= WAKE;
                        wake_cnt        <= CW'(WAKE_CYCLES - 1);
                        clk_gate_core_o <= 1'b1;
                    end
                end
                WAKE: begin
                    if (wake_cnt == '0) begin
                        state      <= RUN;
                        fetch_en_o <= 1'b1;
                    end else begin
                        wake_cnt <= wake_cnt - 1'b1;
                    end
                end
                default: begin
                    state           <= RUN;
                    fetch_en_o      <= 1'b1;
                    clk_gate_core_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_event_ctrl.sv
// Self-checking bench for apb_event_ctrl: directed scenarios plus randomized source and
// pending patterns checked against set-based expectations computed here.
module tb_apb_event_ctrl;

    localparam int AW = 12;
    localparam int NB = 32;
    localparam int SS = 2;
    localparam int WC = 4;

    logic          HCLK, HRESETn;
    logic [AW-1:0] PADDR;
    logic [31:0]   PWDATA, PRDATA;
    logic          PWRITE, PSEL, PENABLE, PREADY, PSLVERR;
    logic [NB-1:0] src_i, irq_o;
    logic          irq_valid_o, irq_ack_i, core_busy_i, fetch_en_o, clk_gate_core_o;
    logic [4:0]    irq_id_o;

    int n_cmp = 0;
    int n_err = 0;

    apb_event_ctrl #(.APB_ADDR_WIDTH(AW), .NB_LINES(NB), .SYNC_STAGES(SS), .WAKE_CYCLES(WC)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
        .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .src_i(src_i), .irq_o(irq_o), .irq_valid_o(irq_valid_o), .irq_id_o(irq_id_o),
        .irq_ack_i(irq_ack_i), .core_busy_i(core_busy_i), .fetch_en_o(fetch_en_o),
        .clk_gate_core_o(clk_gate_core_o)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic step(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    // Called at posedge+1; the write takes effect on the second following edge.
    task automatic apb_write(input logic [AW-1:0] a, input logic [31:0] d);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(posedge HCLK); #1 PENABLE = 1'b1;
        @(posedge HCLK); #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [AW-1:0] a, output logic [31:0] d, output logic e);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(posedge HCLK); #1 PENABLE = 1'b1;
        #1 d = PRDATA; e = PSLVERR;
        @(posedge HCLK); #1 PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic do_reset();
        HRESETn = 1'b0; src_i = '0; irq_ack_i = 1'b0; core_busy_i = 1'b0;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        @(posedge HCLK); #1 HRESETn = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic e;
        do_reset();
        core_busy_i = 1'b1;
        apb_write(12'h000, $urandom | 32'h1);
        apb_write(12'h004, $urandom);
        apb_write(12'h010, $urandom);
        apb_write(12'h008, $urandom | 32'h1);
        src_i = $urandom;
        step(3);
        #2 HRESETn = 1'b0;
        #1;
        n_cmp++;
        if (irq_o !== '0 || irq_valid_o !== 1'b0 || irq_id_o !== 5'd0) begin
            n_err++; $display("FAIL reset_irq: irq_o=%h valid=%b id=%0d want 0/0/0", irq_o, irq_valid_o, irq_id_o);
        end
        n_cmp++;
        if (fetch_en_o !== 1'b1 || clk_gate_core_o !== 1'b1 || PREADY !== 1'b1) begin
            n_err++; $display("FAIL reset_core: fetch=%b gate=%b pready=%b want 1/1/1", fetch_en_o, clk_gate_core_o, PREADY);
        end
        src_i = '0; core_busy_i = 1'b0;
        @(posedge HCLK); #1 HRESETn = 1'b1;
        for (int r = 0; r < 8; r++) begin
            apb_read(AW'(r * 4), d, e);
            n_cmp++;
            if (d !== 32'h0 || e !== 1'b0) begin
                n_err++; $display("FAIL reset_reg%0d: got %h err=%b want 0 err=0", r * 4, d, e);
            end
        end
    endtask

    task automatic test_edge();
        logic [31:0] d; logic e;
        do_reset();
        apb_write(12'h010, 32'h1);
        apb_write(12'h000, 32'h1);
        src_i[0] = 1'b1;
        step(SS + 1);
        n_cmp++;
        if (irq_o[0] !== 1'b0) begin
            n_err++; $display("FAIL edge_early: irq_o[0]=%b want 0 at %0d cycles", irq_o[0], SS + 1);
        end
        step(1);
        n_cmp++;
        if (irq_o !== 32'h1 || irq_valid_o !== 1'b1 || irq_id_o !== 5'd0) begin
            n_err++; $display("FAIL edge_latency: irq_o=%h valid=%b id=%0d want 1/1/0", irq_o, irq_valid_o, irq_id_o);
        end
        irq_ack_i = 1'b1;
        step(1);
        irq_ack_i = 1'b0;
        step(1);
        n_cmp++;
        if (irq_o !== '0 || irq_valid_o !== 1'b0) begin
            n_err++; $display("FAIL edge_ack: irq_o=%h valid=%b want 0/0", irq_o, irq_valid_o);
        end
        step(4);
        apb_read(12'h008, d, e);
        n_cmp++;
        if (d !== 32'h0 || irq_o !== '0) begin
            n_err++; $display("FAIL edge_once: pending=%h irq_o=%h want 0/0 with src held", d, irq_o);
        end
        src_i[0] = 1'b0;
    endtask

    task automatic test_level();
        logic [31:0] d; logic e;
        do_reset();
        src_i[3] = 1'b1;
        step(4);
        apb_read(12'h008, d, e);
        n_cmp++;
        if (d !== 32'h8) begin
            n_err++; $display("FAIL level_set: pending=%h want 00000008", d);
        end
        apb_write(12'h00C, 32'h8);
        apb_read(12'h008, d, e);
        n_cmp++;
        if (d !== 32'h8 || irq_o !== '0) begin
            n_err++; $display("FAIL level_reset: pending=%h irq_o=%h want 8/0", d, irq_o);
        end
        src_i[3] = 1'b0;
        step(3);
        apb_write(12'h00C, 32'h8);
        apb_read(12'h008, d, e);
        n_cmp++;
        if (d !== 32'h0) begin
            n_err++; $display("FAIL level_clear: pending=%h want 0", d);
        end
    endtask

    task automatic test_priority();
        logic [31:0] d, p, m; logic e;
        int q[$];
        for (int it = 0; it < 7; it++) begin
            do_reset();
            p = (it == 0) ? 32'h30 : $urandom;
            m = (it == 0) ? 32'h30 : $urandom;
            q = {};
            for (int i = 0; i < NB; i++) if (p[i] && m[i]) q.push_back(i);
            apb_write(12'h000, m);
            apb_write(12'h008, p);
            step(1);
            while (q.size() > 0) begin
                n_cmp++;
                if (irq_valid_o !== 1'b1 || irq_id_o !== 5'(q[0])) begin
                    n_err++; $display("FAIL prio_id: valid=%b id=%0d want 1/%0d (p=%h m=%h)", irq_valid_o, irq_id_o, q[0], p, m);
                end
                if (q.size() % 4 == 1) begin
                    apb_read(12'h014, d, e);
                    n_cmp++;
                    if (d !== {1'b1, 26'b0, 5'(q[0])}) begin
                        n_err++; $display("FAIL prio_idreg: got %h want id %0d valid", d, q[0]);
                    end
                end
                irq_ack_i = 1'b1;
                step(1);
                irq_ack_i = 1'b0;
                step(1);
                void'(q.pop_front());
            end
            irq_ack_i = 1'b1;
            step(1);
            irq_ack_i = 1'b0;
            step(1);
            apb_read(12'h008, d, e);
            n_cmp++;
            if (irq_valid_o !== 1'b0 || irq_id_o !== 5'd0 || d !== (p & ~m)) begin
                n_err++; $display("FAIL prio_end: valid=%b id=%0d pending=%h want 0/0/%h", irq_valid_o, irq_id_o, d, p & ~m);
            end
        end
    endtask

    task automatic test_random_src();
        logic [31:0] d, es, m, v, prv, expv; logic e;
        for (int it = 0; it < 4; it++) begin
            do_reset();
            es = $urandom; m = $urandom;
            apb_write(12'h010, es);
            apb_write(12'h000, m);
            expv = '0; prv = '0;
            for (int k = 0; k < 8; k++) begin
                v = $urandom & $urandom;
                src_i = v;
                expv = expv | (es & v & ~prv) | (~es & v);
                prv = v;
                step(3);
            end
            step(4);
            apb_read(12'h008, d, e);
            n_cmp++;
            if (d !== expv) begin
                n_err++; $display("FAIL rand_pending: got %h want %h (edge=%h)", d, expv, es);
            end
            n_cmp++;
            if (irq_o !== (expv & m)) begin
                n_err++; $display("FAIL rand_irq: got %h want %h", irq_o, expv & m);
            end
        end
    endtask

    task automatic test_sleep();
        logic [31:0] d; logic e;
        do_reset();
        apb_write(12'h010, 32'h4);
        apb_write(12'h004, 32'h4);
        core_busy_i = 1'b1;
        apb_write(12'h018, 32'h1);
        n_cmp++;
        if (fetch_en_o !== 1'b0 || clk_gate_core_o !== 1'b1) begin
            n_err++; $display("FAIL sleep_wait_out: fetch=%b gate=%b want 0/1", fetch_en_o, clk_gate_core_o);
        end
        apb_read(12'h01C, d, e);
        n_cmp++;
        if (d !== 32'd1) begin
            n_err++; $display("FAIL sleep_status1: got %h want 1", d);
        end
        step(1);
        core_busy_i = 1'b0;
        step(1);
        n_cmp++;
        if (fetch_en_o !== 1'b0 || clk_gate_core_o !== 1'b0) begin
            n_err++; $display("FAIL sleep_gate: fetch=%b gate=%b want 0/0", fetch_en_o, clk_gate_core_o);
        end
        apb_write(12'h018, 32'h1);
        apb_read(12'h01C, d, e);
        n_cmp++;
        if (d !== 32'd2) begin
            n_err++; $display("FAIL sleep_status2: got %h want 2", d);
        end
        src_i[2] = 1'b1;
        step(SS + 1);
        n_cmp++;
        if (clk_gate_core_o !== 1'b0) begin
            n_err++; $display("FAIL wake_early: gate=%b want 0", clk_gate_core_o);
        end
        step(1);
        n_cmp++;
        if (clk_gate_core_o !== 1'b1 || fetch_en_o !== 1'b0) begin
            n_err++; $display("FAIL wake_gate: gate=%b fetch=%b want 1/0", clk_gate_core_o, fetch_en_o);
        end
        for (int k = 1; k < WC; k++) begin
            step(1);
            n_cmp++;
            if (fetch_en_o !== 1'b0 || clk_gate_core_o !== 1'b1) begin
                n_err++; $display("FAIL wake_hold%0d: fetch=%b gate=%b want 0/1", k, fetch_en_o, clk_gate_core_o);
            end
        end
        step(1);
        n_cmp++;
        if (fetch_en_o !== 1'b1 || irq_o !== '0) begin
            n_err++; $display("FAIL wake_fetch: fetch=%b irq_o=%h want 1/0", fetch_en_o, irq_o);
        end
        apb_read(12'h01C, d, e);
        n_cmp++;
        if (d !== 32'd0) begin
            n_err++; $display("FAIL wake_status: got %h want 0", d);
        end
        src_i[2] = 1'b0;
    endtask

    task automatic test_abort();
        logic [31:0] d; logic e;
        do_reset();
        apb_write(12'h004, 32'h1);
        core_busy_i = 1'b1;
        apb_write(12'h018, 32'h1);
        apb_write(12'h008, 32'h1);
        n_cmp++;
        if (fetch_en_o !== 1'b0) begin
            n_err++; $display("FAIL abort_pre: fetch=%b want 0", fetch_en_o);
        end
        step(1);
        apb_read(12'h01C, d, e);
        n_cmp++;
        if (fetch_en_o !== 1'b1 || d !== 32'd0) begin
            n_err++; $display("FAIL abort_run: fetch=%b status=%h want 1/0", fetch_en_o, d);
        end
        apb_write(12'h018, 32'h1);
        n_cmp++;
        if (fetch_en_o !== 1'b0 || clk_gate_core_o !== 1'b1) begin
            n_err++; $display("FAIL same_cycle_wait: fetch=%b gate=%b want 0/1", fetch_en_o, clk_gate_core_o);
        end
        step(1);
        n_cmp++;
        if (fetch_en_o !== 1'b1) begin
            n_err++; $display("FAIL same_cycle_abort: fetch=%b want 1", fetch_en_o);
        end
        core_busy_i = 1'b0;
    endtask

    task automatic test_slverr();
        logic [31:0] d; logic e;
        do_reset();
        apb_read(12'h024, d, e);
        n_cmp++;
        if (e !== 1'b1 || d !== 32'h0) begin
            n_err++; $display("FAIL slverr_read: err=%b data=%h want 1/0", e, d);
        end
        apb_write(12'h020, 32'hFFFF_FFFF);
        apb_write(12'h028, 32'hFFFF_FFFF);
        apb_read(12'h000, d, e);
        n_cmp++;
        if (e !== 1'b0 || d !== 32'h0) begin
            n_err++; $display("FAIL slverr_nowrite: mask_irq=%h err=%b want 0/0", d, e);
        end
        apb_read(12'h008, d, e);
        n_cmp++;
        if (d !== 32'h0) begin
            n_err++; $display("FAIL slverr_nopend: pending=%h want 0", d);
        end
        apb_write(12'h010, 32'h2);
        src_i[1] = 1'b1;
        step(1);
        apb_write(12'h00C, 32'h2);
        apb_read(12'h008, d, e);
        n_cmp++;
        if (d !== 32'h2) begin
            n_err++; $display("FAIL set_wins: pending=%h want 00000002", d);
        end
        src_i[1] = 1'b0;
    endtask

    initial begin
        HRESETn = 1'b0; src_i = '0; irq_ack_i = 1'b0; core_busy_i = 1'b0;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        @(posedge HCLK); #1;
        test_reset();
        test_edge();
        test_level();
        test_priority();
        test_random_src();
        test_sleep();
        test_abort();
        test_slverr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
